// File: rtl/tx_system_data.sv
// System-side message source for the UART transmitter.
// Sends BYTE0..BYTE3 with a per-byte write/busy handshake and an inter-message gap.
module tx_system_data #(
    parameter logic [7:0]  BYTE0       = 8'hAA,
    parameter logic [7:0]  BYTE1       = 8'h55,
    parameter logic [7:0]  BYTE2       = 8'hCC,
    parameter logic [7:0]  BYTE3       = 8'h89,
    parameter logic [2:0]  BAUD_SEL    = 3'b111,
    parameter bit          AUTO_REPEAT = 1'b0,
    parameter logic [15:0] GAP_CYCLES  = 16'd1000,
    parameter logic [15:0] ACK_TIMEOUT = 16'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic       Tx_BUSY,
    output logic       Tx_EN,
    output logic       Tx_WR,
    output logic [7:0] Tx_DATA,
    output logic [2:0] Tx_baud_select,
    output logic [1:0] byte_index,
    output logic       msg_done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        WAIT_HI,
        WAIT_LO,
        GAP
    } state_t;

    state_t      state;
    logic        send_d;
    logic        send_rise;
    logic [15:0] ack_cnt;
    logic [15:0] gap_cnt;
    logic [15:0] ack_inc;
    logic [15:0] gap_inc;
    logic        ack_hit;
    logic        gap_hit;

    assign send_rise      = send & ~send_d;
    assign Tx_baud_select = BAUD_SEL;

    // Saturating counters; "hit" fires on the last cycle of the window
    assign ack_inc = (ack_cnt == 16'hFFFF) ? ack_cnt : ack_cnt + 16'd1;
    assign gap_inc = (gap_cnt == 16'hFFFF) ? gap_cnt : gap_cnt + 16'd1;
    assign ack_hit = ({1'b0, ack_cnt} + 17'd1) >= {1'b0, ACK_TIMEOUT};
    assign gap_hit = ({1'b0, gap_cnt} + 17'd1) >= {1'b0, GAP_CYCLES};

    function automatic logic [7:0] byte_at(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = BYTE0;
            2'd1:    b = BYTE1;
            2'd2:    b = BYTE2;
            default: b = BYTE3;
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            send_d     <= 1'b0;
            ack_cnt    <= 16'd0;
            gap_cnt    <= 16'd0;
            Tx_EN      <= 1'b0;
            Tx_WR      <= 1'b0;
            Tx_DATA    <= 8'h00;
            byte_index <= 2'd0;
            msg_done   <= 1'b0;
        end else begin
            send_d   <= send;
            Tx_WR    <= 1'b0;
            msg_done <= 1'b0;
            case (state)
                IDLE: begin
                    Tx_EN <= 1'b0;
                    if (send_rise || AUTO_REPEAT) begin
                        byte_index <= 2'd0;
                        Tx_DATA    <= BYTE0;
                        Tx_EN      <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    Tx_EN   <= 1'b1;
                    Tx_DATA <= byte_at(byte_index);
                    if (!Tx_BUSY) begin
                        Tx_WR <= 1'b1;
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    ack_cnt <= 16'd0;
                    state   <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (Tx_BUSY) begin
                        state <= WAIT_LO;
                    end else if (ack_hit) begin
                        state <= LOAD;
                    end else begin
                        ack_cnt <= ack_inc;
                    end
                end
                WAIT_LO: begin
                    if (!Tx_BUSY) begin
                        if (byte_index == 2'd3) begin
                            msg_done <= 1'b1;
                            Tx_EN    <= 1'b0;
                            gap_cnt  <= 16'd0;
                            state    <= GAP;
                        end else begin
                            byte_index <= byte_index + 2'd1;
                            Tx_DATA    <= byte_at(byte_index + 2'd1);
                            state      <= LOAD;
                        end
                    end
                end
                GAP: begin
                    Tx_EN <= 1'b0;
                    if (gap_hit) begin
                        if (AUTO_REPEAT) begin
                            byte_index <= 2'd0;
                            Tx_DATA    <= BYTE0;
                            Tx_EN      <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_system_data.sv
// Bench for tx_system_data: a cycle-level transmitter model answers Tx_WR,
// and message events are compared against the expected byte/timing rules.
module tb_tx_system_data;

    logic       clk = 1'b0;
    logic       rst0, rst1, send0, send1, busy;
    logic       en0, wr0, md0, en1, wr1, md1;
    logic [7:0] d0, d1;
    logic [2:0] bs0, bs1;
    logic [1:0] bi0, bi1;
    logic       sel;
    logic       o_en, o_wr, o_md;
    logic [7:0] o_d;

    always #5 clk = ~clk;

    tx_system_data #(.GAP_CYCLES(16'd40)) u0 (
        .clk(clk), .reset(rst0), .send(send0), .Tx_BUSY(busy),
        .Tx_EN(en0), .Tx_WR(wr0), .Tx_DATA(d0), .Tx_baud_select(bs0),
        .byte_index(bi0), .msg_done(md0)
    );

    tx_system_data #(.AUTO_REPEAT(1'b1), .GAP_CYCLES(16'd8)) u1 (
        .clk(clk), .reset(rst1), .send(send1), .Tx_BUSY(busy),
        .Tx_EN(en1), .Tx_WR(wr1), .Tx_DATA(d1), .Tx_baud_select(bs1),
        .byte_index(bi1), .msg_done(md1)
    );

    always_comb begin
        o_en = sel ? en1 : en0;
        o_wr = sel ? wr1 : wr0;
        o_md = sel ? md1 : md0;
        o_d  = sel ? d1  : d0;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] msg [4] = '{8'hAA, 8'h55, 8'hCC, 8'h89};

    int busy_left, delay, blen, ignore_n, hold_until, fixed_len;
    bit rand_mode;
    logic [7:0] wr_q[$];
    int wr_t[$], fall_t[$], done_t[$], rise_t[$];
    int en_low, b2b, wr_busy;
    bit in_msg, prev_wr, prev_en;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wr_q.delete(); wr_t.delete(); fall_t.delete();
        done_t.delete(); rise_t.delete();
        en_low = 0; b2b = 0; wr_busy = 0; in_msg = 0;
    endtask

    // One clock of the transmitter model, observed and driven at negedge
    task automatic tick();
        bit nb;
        @(negedge clk);
        if (o_md) begin
            done_t.push_back(cyc);
            in_msg = 0;
        end
        if (in_msg && !o_en) en_low++;
        if (o_en && !prev_en) rise_t.push_back(cyc);
        prev_en = o_en;
        if (o_wr) begin
            wr_q.push_back(o_d);
            wr_t.push_back(cyc);
            if (prev_wr) b2b++;
            if (busy) wr_busy++;
            in_msg = 1;
            if (ignore_n > 0) ignore_n--;
            else begin
                delay = rand_mode ? int'($urandom_range(3, 0)) : 0;
                blen  = rand_mode ? int'($urandom_range(15, 2)) : fixed_len;
            end
        end
        prev_wr = o_wr;
        if (delay == 0) begin
            busy_left = blen;
            delay = -1;
        end else if (delay > 0) begin
            delay--;
        end
        nb = 1'b0;
        if (cyc < hold_until) nb = 1'b1;
        else if (busy_left > 0) begin
            nb = 1'b1;
            busy_left--;
        end
        if (busy && !nb) fall_t.push_back(cyc);
        busy = nb;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    task automatic wait_wr(int n, int limit);
        int k = 0;
        while (wr_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk("wr_seen", 32'(wr_q.size() >= n), 1);
    endtask

    task automatic wait_done(int n, int limit);
        int k = 0;
        while (done_t.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk("done_seen", done_t.size(), n);
    endtask

    // Bytes in order; next write 2 cycles after a busy fall; done 1 after last fall
    task automatic check_msg(string tag, int wb, int fb, int db);
        bit ok;
        ok = wr_q.size() >= wb + 4 && fall_t.size() >= fb + 4 && done_t.size() > db;
        chk({tag, "_events"}, 32'(ok), 1);
        if (ok) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_data%0d", tag, k), wr_q[wb+k], msg[k]);
            for (int k = 0; k < 3; k++)
                chk($sformatf("%s_space%0d", tag, k), wr_t[wb+k+1] - fall_t[fb+k], 2);
            chk({tag, "_done_t"}, done_t[db] - fall_t[fb+3], 1);
        end
    endtask

    task automatic check_proto(string tag);
        chk({tag, "_en_gap"}, en_low, 0);
        chk({tag, "_wr_b2b"}, b2b, 0);
        chk({tag, "_wr_busy"}, wr_busy, 0);
    endtask

    initial begin
        int e0;
        rst0 = 0; rst1 = 0; send0 = 0; send1 = 0; busy = 0; sel = 0;
        busy_left = 0; delay = -1; blen = 0; ignore_n = 0; hold_until = 0;
        fixed_len = 10; rand_mode = 0; prev_wr = 0; prev_en = 0;
        clr();
        repeat (3) @(negedge clk);

        chk("rst_en", en0, 0);
        chk("rst_wr", wr0, 0);
        chk("rst_data", d0, 8'h00);
        chk("rst_idx", bi0, 0);
        chk("rst_done", md0, 0);
        chk("baud", bs0, 3'b111);
        chk("rst1_en", en1, 0);
        chk("rst1_idx", bi1, 0);
        chk("baud1", bs1, 3'b111);
        rst0 = 1;
        ticks(4);

        // Latency and single message, busy 10 cycles per byte
        clr();
        e0 = cyc;
        send0 = 1;
        tick();
        send0 = 0;
        wait_done(1, 400);
        if (wr_t.size() > 0) begin
            chk("lat_wr", wr_t[0] - e0, 2);
            chk("lat_load", rise_t[0] - e0, 1);
        end
        check_msg("single", 0, 0, 0);
        check_proto("single");
        ticks(60);
        chk("single_idle_wr", wr_q.size(), 4);
        chk("single_idle_en", en0, 0);
        chk("single_en_rises", rise_t.size(), 1);

        // Busy stuck high on entering LOAD for 20 cycles
        clr();
        busy = 1;
        hold_until = cyc + 21;
        send0 = 1;
        tick();
        send0 = 0;
        wait_done(1, 400);
        if (wr_t.size() > 0 && fall_t.size() > 0)
            chk("hold_wr", wr_t[0] - fall_t[0], 1);
        check_msg("hold", 0, 1, 0);
        check_proto("hold");
        ticks(60);

        // First write ignored by transmitter: re-issue after timeout
        clr();
        ignore_n = 1;
        send0 = 1;
        tick();
        send0 = 0;
        wait_wr(2, 400);
        if (wr_q.size() >= 2) begin
            chk("tmo_gap", wr_t[1] - wr_t[0], 255 + 2);
            chk("tmo_data", wr_q[1], 8'hAA);
        end
        wait_done(1, 400);
        check_msg("tmo", 1, 0, 0);
        check_proto("tmo");
        ticks(60);

        // Random busy timing; extra send rises mid-message are dropped
        rand_mode = 1;
        for (int m = 0; m < 3; m++) begin
            clr();
            send0 = 1;
            tick();
            send0 = 0;
            ticks(6);
            send0 = 1;
            ticks(2);
            send0 = 0;
            wait_done(1, 400);
            check_msg($sformatf("rnd%0d", m), 0, 0, 0);
            check_proto($sformatf("rnd%0d", m));
            ticks(60);
            chk($sformatf("rnd%0d_count", m), wr_q.size(), 4);
        end

        // Reset during WAIT_LO of byte 1
        rand_mode = 0;
        clr();
        send0 = 1;
        tick();
        send0 = 0;
        wait_wr(2, 400);
        ticks(3);
        chk("mid_idx", bi0, 1);
        #2 rst0 = 0;
        #1;
        chk("arst_en", en0, 0);
        chk("arst_wr", wr0, 0);
        chk("arst_data", d0, 8'h00);
        chk("arst_idx", bi0, 0);
        chk("arst_done", md0, 0);
        busy_left = 0; delay = -1; busy = 0;
        ticks(2);
        rst0 = 1;
        clr();
        ticks(30);
        chk("post_rst_wr", wr_q.size(), 0);
        chk("post_rst_en", rise_t.size(), 0);
        send0 = 1;
        tick();
        send0 = 0;
        wait_done(1, 400);
        check_msg("restart", 0, 0, 0);
        check_proto("restart");
        ticks(60);

        // Auto-repeat instance, gap of 8
        sel = 1;
        rand_mode = 1;
        prev_en = 0;
        prev_wr = 0;
        clr();
        rst1 = 1;
        ticks(10);
        send1 = 1;
        ticks(3);
        send1 = 0;
        wait_done(2, 2000);
        check_msg("auto0", 0, 0, 0);
        check_msg("auto1", 4, 4, 1);
        check_proto("auto");
        if (rise_t.size() >= 2 && done_t.size() >= 1 && wr_t.size() >= 5) begin
            chk("auto_gap", rise_t[1] - done_t[0], 8);
            chk("auto_wr", wr_t[4] - done_t[0], 9);
        end else begin
            chk("auto_rises", 32'(rise_t.size() >= 2 && wr_t.size() >= 5), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
